// File: rtl/float_fixed_conversion_pkg.sv
// Shared widths, saturation constant, FSM states and input classes for the
// float-to-fixed converter.
package float_fixed_conversion_pkg;

  localparam int unsigned FIXED_W  = 22;
  localparam int unsigned FRAC_W   = 20;
  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned MANT_W   = 23;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MAG_W    = FIXED_W - 1;
  localparam int unsigned SH_W     = 5;

  localparam logic [MAG_W-1:0] SAT_MAG = 21'h1FFFFF;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    NORMAL,
    ZERO,
    OVF,
    NAN
  } cls_t;

endpackage

// File: rtl/float_fixed_conversion_classify.sv
// Combinational IEEE-754 single classification and right-shift amount for
// alignment into the 1.20 fixed-point grid.
module float_classify
  import float_fixed_conversion_pkg::*;
(
  input  logic [EXP_W-1:0]  e,
  input  logic [MANT_W-1:0] m,
  output cls_t              cls,
  output logic [SH_W-1:0]   sh
);

  // 23 mantissa bits minus 20 fraction bits, plus the bias
  localparam int unsigned SH_BASE = MANT_W - FRAC_W + EXP_BIAS;

  logic [EXP_W:0] diff;

  always_comb begin
    diff = (EXP_W+1)'(SH_BASE) - (EXP_W+1)'(e);
    cls  = NORMAL;
    sh   = diff[SH_W-1:0];
    if (e == {EXP_W{1'b1}}) begin
      cls = (m != '0) ? NAN : OVF;
    end else if (e > EXP_W'(EXP_BIAS)) begin
      cls = OVF;
    end else if (e == '0) begin
      cls = ZERO;
    end else if (diff >= (EXP_W+1)'(MANT_W + 1)) begin
      // everything shifts out: underflow to zero
      cls = ZERO;
      sh  = SH_W'(MANT_W + 1);
    end
  end

endmodule

// File: rtl/float_fixed_conversion.sv
// IEEE-754 single to 22-bit sign-magnitude 1.20 fixed point, one right shift
// per clock, with saturation and NaN flagging on an enable/done handshake.
module float_fixed_conversion
  import float_fixed_conversion_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [31:0]        data,
  output logic [FIXED_W-1:0] result,
  output logic               done,
  output logic               overflow,
  output logic               invalid
);

  state_t            state;
  cls_t              cls;
  cls_t              cls_c;
  logic [SH_W-1:0]   sh_c;
  logic [SH_W-1:0]   cnt;
  logic [MANT_W:0]   sig;
  logic              sgn;

  float_classify u_classify (
    .e   (data[30:23]),
    .m   (data[22:0]),
    .cls (cls_c),
    .sh  (sh_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cls      <= NORMAL;
      cnt      <= '0;
      sig      <= '0;
      sgn      <= 1'b0;
      result   <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            sgn   <= data[31];
            sig   <= {1'b1, data[22:0]};
            cnt   <= (cls_c == NORMAL) ? sh_c : '0;
            cls   <= cls_c;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!enable) begin
            state <= IDLE;
          end else if (cnt != '0) begin
            sig <= sig >> 1;
            cnt <= cnt - SH_W'(1);
          end else begin
            // zero magnitude never carries a sign
            case (cls)
              NORMAL: begin
                result   <= {sgn & (|sig[MAG_W-1:0]), sig[MAG_W-1:0]};
                overflow <= 1'b0;
                invalid  <= 1'b0;
              end
              OVF: begin
                result   <= {sgn, SAT_MAG};
                overflow <= 1'b1;
                invalid  <= 1'b0;
              end
              NAN: begin
                result   <= '0;
                overflow <= 1'b0;
                invalid  <= 1'b1;
              end
              default: begin
                result   <= '0;
                overflow <= 1'b0;
                invalid  <= 1'b0;
              end
            endcase
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (!enable) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_fixed_conversion.sv
// Scoreboard bench for float_fixed_conversion: directed, random, handshake
// and asynchronous reset scenarios.
module tb_float_fixed_conversion;

  typedef struct {
    logic [21:0] res;
    logic        ovf;
    logic        inv;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] data;
  logic [21:0] result;
  logic        done;
  logic        overflow;
  logic        invalid;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  float_fixed_conversion dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .data     (data),
    .result   (result),
    .done     (done),
    .overflow (overflow),
    .invalid  (invalid)
  );

  always #5 clk = ~clk;

  // Reference: real-number semantics expressed as a single shift of the significand
  function automatic exp_t model(input logic [31:0] d);
    exp_t        x;
    int          e;
    int          sh;
    logic [23:0] sig;
    logic [23:0] shifted;
    e   = int'(d[30:23]);
    sig = {1'b1, d[22:0]};
    x.res = 22'h0; x.ovf = 1'b0; x.inv = 1'b0; x.lat = 1;
    if (e == 255 && d[22:0] != 23'h0) begin
      x.inv = 1'b1;
    end else if (e >= 128) begin
      x.res = {d[31], 21'h1FFFFF};
      x.ovf = 1'b1;
    end else if (e != 0 && e >= 107) begin
      sh      = 130 - e;
      shifted = sig >> sh;
      x.res   = {d[31] & (shifted[20:0] != 21'h0), shifted[20:0]};
      x.lat   = sh + 1;
    end
    return x;
  endfunction

  task automatic run_conv(input logic [31:0] d, input logic [21:0] er,
                          input logic eo, input logic ei, input int el);
    exp_t x;
    int   lat;
    bit   got;
    x.res = er; x.ovf = eo; x.inv = ei; x.lat = el;
    sb.push_back(x);
    @(negedge clk);
    data   = d;
    enable = 1'b1;
    @(posedge clk);
    #1 data = $urandom;
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        got = 1'b1;
        break;
      end
    end
    x = sb.pop_front();
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL timeout data=%h: done never rose within 40 cycles", d);
    end else begin
      n_checks++;
      if (lat !== x.lat) begin
        n_fail++;
        $display("FAIL latency data=%h: got %0d expected %0d", d, lat, x.lat);
      end
      n_checks++;
      if (result !== x.res) begin
        n_fail++;
        $display("FAIL result data=%h: got %h expected %h", d, result, x.res);
      end
      n_checks++;
      if (overflow !== x.ovf || invalid !== x.inv) begin
        n_fail++;
        $display("FAIL flags data=%h: got ovf=%b inv=%b expected ovf=%b inv=%b",
                 d, overflow, invalid, x.ovf, x.inv);
      end
    end
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_clear data=%h: got %b expected 0", d, done);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    data   = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({result, done, overflow, invalid} !== 25'h0) begin
      n_fail++;
      $display("FAIL reset_values: got res=%h done=%b ovf=%b inv=%b expected all 0",
               result, done, overflow, invalid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({result, done, overflow, invalid} !== 25'h0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got res=%h done=%b expected 0", result, done);
    end
  endtask

  task automatic test_directed();
    logic [31:0] din  [8] = '{32'h3FC00000, 32'hBF000000, 32'h40000000, 32'hFF800000,
                              32'h7FC00000, 32'h80000000, 32'h33800000, 32'h35800000};
    logic [21:0] eres [8] = '{22'h180000, 22'h280000, 22'h1FFFFF, 22'h3FFFFF,
                              22'h000000, 22'h000000, 22'h000000, 22'h000001};
    logic        eovf [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        einv [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int          elat [8] = '{4, 5, 1, 1, 1, 1, 1, 24};
    for (int i = 0; i < 8; i++) run_conv(din[i], eres[i], eovf[i], einv[i], elat[i]);
  endtask

  task automatic test_random();
    logic [31:0] d;
    int          r;
    exp_t        x;
    for (int i = 0; i < 24; i++) begin
      r = int'($urandom_range(0, 9));
      d = $urandom;
      if (r == 0)      d[30:23] = 8'hFF;
      else if (r == 1) d[30:23] = 8'h00;
      else             d[30:23] = 8'($urandom_range(100, 135));
      x = model(d);
      run_conv(d, x.res, x.ovf, x.inv, x.lat);
    end
  endtask

  task automatic test_hold();
    bit got;
    @(negedge clk);
    data   = 32'h3FC00000;
    enable = 1'b1;
    got    = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk);
      #1 got = done;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL hold_timeout: done never rose");
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      data = $urandom;
      @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b1 || result !== 22'h180000) begin
        n_fail++;
        $display("FAIL hold_stable cycle %0d: got done=%b res=%h expected 1 180000",
                 k, done, result);
      end
    end
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || result !== 22'h180000) begin
      n_fail++;
      $display("FAIL hold_release: got done=%b res=%h expected 0 180000", done, result);
    end
  endtask

  task automatic test_abort();
    bit bad;
    run_conv(32'h3FC00000, 22'h180000, 1'b0, 1'b0, 4);
    @(negedge clk);
    data   = 32'h35800000;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || result !== 22'h180000 || overflow !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL abort: got done=%b res=%h expected done 0 res 180000", done, result);
    end
  endtask

  task automatic test_async_reset();
    run_conv(32'hFF800000, 22'h3FFFFF, 1'b1, 1'b0, 1);
    @(negedge clk);
    data   = 32'h35800000;
    enable = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (result !== 22'h0 || done !== 1'b0 || overflow !== 1'b0 || invalid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got res=%h done=%b ovf=%b inv=%b expected all 0",
               result, done, overflow, invalid);
    end
    enable = 1'b0;
    #1 rst_n = 1'b1;
    run_conv(32'hBF000000, 22'h280000, 1'b0, 1'b0, 5);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
